// File: rtl/axis_demux_pkt_pkg.sv
// Shared types for the AXI-Stream packet demultiplexer.
package axis_demux_pkt_pkg;

  // Packet-routing FSM: no packet open, or a packet locked to M0 / M1.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT0 = 2'd1,
    ST_PKT1 = 2'd2
  } state_t;

endpackage

// File: rtl/axis_demux_pkt_if.sv
// Stream bundle for the demux: slave input stream, route select, two master streams.
interface axis_demux_pkt_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  sel;
  logic [DATA_WIDTH-1:0] S_TDATA;
  logic                  S_TVALID;
  logic                  S_TLAST;
  logic                  S_TREADY;
  logic [DATA_WIDTH-1:0] M0_TDATA;
  logic                  M0_TVALID;
  logic                  M0_TLAST;
  logic                  M0_TREADY;
  logic [DATA_WIDTH-1:0] M1_TDATA;
  logic                  M1_TVALID;
  logic                  M1_TLAST;
  logic                  M1_TREADY;

  // Environment side: drives the slave stream and master readies.
  modport master (
    output sel, S_TDATA, S_TVALID, S_TLAST, M0_TREADY, M1_TREADY,
    input  S_TREADY, M0_TDATA, M0_TVALID, M0_TLAST, M1_TDATA, M1_TVALID, M1_TLAST
  );

  // Demux side: consumes the slave stream, produces both master streams.
  modport slave (
    input  sel, S_TDATA, S_TVALID, S_TLAST, M0_TREADY, M1_TREADY,
    output S_TREADY, M0_TDATA, M0_TVALID, M0_TLAST, M1_TDATA, M1_TVALID, M1_TLAST
  );
endinterface

// File: rtl/axis_demux_pkt_out_reg.sv
// One registered AXI-Stream master output stage (valid/data/last).
module axis_out_reg #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic                  din_last,
  input  logic                  tready,
  output logic                  tvalid,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic                  tlast,
  output logic                  free
);

  // Register can take a new beat when empty or being drained this cycle.
  assign free = !tvalid || tready;

  // Load wins over drain so a simultaneous drain+load keeps TVALID high.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      tvalid <= 1'b0;
      tdata  <= '0;
      tlast  <= 1'b0;
    end else if (load) begin
      tvalid <= 1'b1;
      tdata  <= din_data;
      tlast  <= din_last;
    end else if (tready) begin
      tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_demux_pkt.sv
// 1-to-2 AXI-Stream packet demux: route locked on first beat until TLAST.
module axis_demux_pkt
  import axis_demux_pkt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic              ACLK,
  input logic              ARESET,
  axis_demux_pkt_if.slave  bus
);

  state_t state_q, state_d;
  logic   dest;
  logic   free0, free1;
  logic   accept;
  logic   load0, load1;

  // State register.
  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Destination select, ready, per-port load and next state.
  always_comb begin
    state_d = state_q;
    dest    = 1'b0;
    case (state_q)
      ST_IDLE: dest = bus.sel;
      ST_PKT0: dest = 1'b0;
      ST_PKT1: dest = 1'b1;
      default: dest = 1'b0;
    endcase
    // Only the destination's register gates ready: head-of-line blocking.
    bus.S_TREADY = dest ? free1 : free0;
    accept       = bus.S_TVALID && bus.S_TREADY;
    load0        = accept && !dest;
    load1        = accept && dest;
    if (state_q != ST_IDLE && state_q != ST_PKT0 && state_q != ST_PKT1)
      state_d = ST_IDLE;
    if (accept) begin
      if (bus.S_TLAST) state_d = ST_IDLE;
      else             state_d = dest ? ST_PKT1 : ST_PKT0;
    end
  end

  axis_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out0 (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .load     (load0),
    .din_data (bus.S_TDATA),
    .din_last (bus.S_TLAST),
    .tready   (bus.M0_TREADY),
    .tvalid   (bus.M0_TVALID),
    .tdata    (bus.M0_TDATA),
    .tlast    (bus.M0_TLAST),
    .free     (free0)
  );

  axis_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out1 (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .load     (load1),
    .din_data (bus.S_TDATA),
    .din_last (bus.S_TLAST),
    .tready   (bus.M1_TREADY),
    .tvalid   (bus.M1_TVALID),
    .tdata    (bus.M1_TDATA),
    .tlast    (bus.M1_TLAST),
    .free     (free1)
  );

endmodule

// File: tb/tb_axis_demux_pkt.sv
// Directed, table-driven bench for axis_demux_pkt.
module tb_axis_demux_pkt;
  import axis_demux_pkt_pkg::*;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic ACLK;
  logic ARESET;

  axis_demux_pkt_if #(.DATA_WIDTH(8)) bus ();

  axis_demux_pkt #(.DATA_WIDTH(8)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Inputs for one cycle, expected S_TREADY before the edge, expected outputs after it.
  typedef struct {
    logic       rst;
    logic       sel;
    logic [7:0] d;
    logic       v;
    logic       l;
    logic       r0;
    logic       r1;
    logic       chk_rdy;
    logic       rdy;
    logic       m0v;
    logic [7:0] m0d;
    logic       m0l;
    logic       m1v;
    logic [7:0] m1d;
    logic       m1l;
    logic       chk_idle;
  } vec_t;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  vec_t tbl[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t t, input string tag);
    ARESET        = t.rst;
    bus.sel       = t.sel;
    bus.S_TDATA   = t.d;
    bus.S_TVALID  = t.v;
    bus.S_TLAST   = t.l;
    bus.M0_TREADY = t.r0;
    bus.M1_TREADY = t.r1;
    #1;
    if (t.chk_rdy) check({tag, ".s_tready"}, 32'(bus.S_TREADY), 32'(t.rdy));
    @(posedge ACLK);
    #1;
    check({tag, ".m0_tvalid"}, 32'(bus.M0_TVALID), 32'(t.m0v));
    check({tag, ".m0_tdata"},  32'(bus.M0_TDATA),  32'(t.m0d));
    check({tag, ".m0_tlast"},  32'(bus.M0_TLAST),  32'(t.m0l));
    check({tag, ".m1_tvalid"}, 32'(bus.M1_TVALID), 32'(t.m1v));
    check({tag, ".m1_tdata"},  32'(bus.M1_TDATA),  32'(t.m1d));
    check({tag, ".m1_tlast"},  32'(bus.M1_TLAST),  32'(t.m1l));
    if (t.chk_idle) check({tag, ".state_idle"}, 32'(dut.state_q), 32'(ST_IDLE));
  endtask

  initial begin
    ARESET = H; bus.sel = L; bus.S_TDATA = '0; bus.S_TVALID = L; bus.S_TLAST = L;
    bus.M0_TREADY = H; bus.M1_TREADY = H;

    //          rst sel d      v  l  r0 r1  crdy rdy  m0v m0d   m0l  m1v m1d   m1l  idle
    // Reset with S_TVALID high, then idle.
    tbl[0]  = '{H, L, 8'h77, H, L, H, H,  L, L,  L, 8'h00, L,  L, 8'h00, L,  H};
    tbl[1]  = '{H, L, 8'h77, H, L, H, H,  H, H,  L, 8'h00, L,  L, 8'h00, L,  H};
    tbl[2]  = '{L, L, 8'h00, L, L, H, H,  H, H,  L, 8'h00, L,  L, 8'h00, L,  H};
    // Three-beat packet to M1.
    tbl[3]  = '{L, H, 8'h11, H, L, H, H,  H, H,  L, 8'h00, L,  H, 8'h11, L,  L};
    tbl[4]  = '{L, H, 8'h22, H, L, H, H,  H, H,  L, 8'h00, L,  H, 8'h22, L,  L};
    tbl[5]  = '{L, H, 8'h33, H, H, H, H,  H, H,  L, 8'h00, L,  H, 8'h33, H,  H};
    tbl[6]  = '{L, L, 8'h00, L, L, H, H,  H, H,  L, 8'h00, L,  L, 8'h33, H,  H};
    // sel toggled mid-packet is ignored; next packet right after TLAST goes to M1.
    tbl[7]  = '{L, L, 8'hA0, H, L, H, H,  H, H,  H, 8'hA0, L,  L, 8'h33, H,  L};
    tbl[8]  = '{L, H, 8'hA1, H, L, H, H,  H, H,  H, 8'hA1, L,  L, 8'h33, H,  L};
    tbl[9]  = '{L, H, 8'hA2, H, H, H, H,  H, H,  H, 8'hA2, H,  L, 8'h33, H,  H};
    tbl[10] = '{L, H, 8'hB0, H, H, H, H,  H, H,  L, 8'hA2, H,  H, 8'hB0, H,  H};
    tbl[11] = '{L, L, 8'h00, L, L, H, H,  H, H,  L, 8'hA2, H,  L, 8'hB0, H,  H};
    // Backpressure on M0 for three cycles.
    tbl[12] = '{L, L, 8'h01, H, L, L, H,  H, H,  H, 8'h01, L,  L, 8'hB0, H,  L};
    tbl[13] = '{L, L, 8'h02, H, L, L, H,  H, L,  H, 8'h01, L,  L, 8'hB0, H,  L};
    tbl[14] = '{L, L, 8'h02, H, L, L, H,  H, L,  H, 8'h01, L,  L, 8'hB0, H,  L};
    tbl[15] = '{L, L, 8'h02, H, L, H, H,  H, H,  H, 8'h02, L,  L, 8'hB0, H,  L};
    tbl[16] = '{L, L, 8'h03, H, H, H, H,  H, H,  H, 8'h03, H,  L, 8'hB0, H,  H};
    tbl[17] = '{L, L, 8'h00, L, L, H, H,  H, H,  L, 8'h03, H,  L, 8'hB0, H,  H};

    #1;
    for (int i = 0; i < 18; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Head-of-line: M1 holds 0x55, a sel=1 packet stalls, a sel=0 packet passes to M0.
    run_vec('{L, H, 8'h55, H, H, H, L,  H, H,  L, 8'h03, H,  H, 8'h55, H,  H}, "hol0");
    run_vec('{L, H, 8'h77, H, L, H, L,  H, L,  L, 8'h03, H,  H, 8'h55, H,  H}, "hol1");
    run_vec('{L, L, 8'h66, H, H, H, L,  H, H,  H, 8'h66, H,  H, 8'h55, H,  H}, "hol2");
    run_vec('{L, L, 8'h00, L, L, H, L,  H, H,  L, 8'h66, H,  H, 8'h55, H,  H}, "hol3");
    run_vec('{L, L, 8'h00, L, L, H, H,  H, H,  L, 8'h66, H,  L, 8'h55, H,  H}, "hol4");

    // Reset after two of four beats to M0, then a fresh packet to M1.
    run_vec('{L, L, 8'hC1, H, L, H, H,  H, H,  H, 8'hC1, L,  L, 8'h55, H,  L}, "rst0");
    run_vec('{L, L, 8'hC2, H, L, H, H,  H, H,  H, 8'hC2, L,  L, 8'h55, H,  L}, "rst1");
    check("rst1.state_pkt0", 32'(dut.state_q), 32'(ST_PKT0));
    run_vec('{H, L, 8'hC3, H, L, H, H,  H, H,  L, 8'h00, L,  L, 8'h00, L,  H}, "rst2");
    run_vec('{L, H, 8'hD0, H, H, H, H,  H, H,  L, 8'h00, L,  H, 8'hD0, H,  H}, "rst3");
    run_vec('{L, H, 8'h00, L, L, H, H,  H, H,  L, 8'h00, L,  L, 8'hD0, H,  H}, "rst4");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
